ex_hazard_controller: RTL
=========================

Name: ex_hazard_controller

Overview:
- Pipeline controller for the 16-bit MIPS execute stage.
- Keeps its own shadow pipeline of destination and control info for the EX, MEM and WB slots.
- From it, drives the EX operand forwarding selects and inserts one-cycle load-use stalls.
- Resolves branches from the EX zero flag and branch target, then flushes the wrong-path instructions.
- Sits beside the decode and execute stages and feeds the PC mux, IF/ID and ID/EX register controls.

Parameters:
- REG_ADDR_W, 3: register-file address width (8 registers; register 0 reads as zero and is never written).
- DATA_W, 16: width of the PC and branch target.
- CNT_W, 16: width of the stall and flush event counters.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_ID_Valid  in  1  a real instruction is in ID
- in_ID_Rs  in  REG_ADDR_W  ID source register A
- in_ID_Rt  in  REG_ADDR_W  ID source register B
- in_ID_Uses_Rs  in  1  ID instruction reads Rs
- in_ID_Uses_Rt  in  1  ID instruction reads Rt (not asserted for immediate-only operands)
- in_ID_Rd  in  REG_ADDR_W  ID destination register
- in_ID_RegWrite  in  1  ID instruction writes Rd
- in_ID_MemRead  in  1  ID instruction is a load
- in_ID_Branch  in  1  ID instruction is a conditional branch
- in_EX_Zero  in  1  ALU zero flag from the execute stage
- in_EX_addResult  in  DATA_W  branch target computed in the execute stage
- O_Stall  out  1  hold PC and IF/ID this cycle
- O_Flush  out  1  clear IF/ID this cycle
- O_IDEX_Bubble  out  1  load a bubble into ID/EX at this edge
- O_FwdA  out  2  operand A select for the instruction in EX
- O_FwdB  out  2  operand B select for the instruction in EX
- O_PC_Src  out  1  1 selects the branch target
- O_Branch_Target  out  DATA_W  next PC when O_PC_Src=1
- O_Stall_Count  out  CNT_W  number of load-use stall cycles
- O_Flush_Count  out  CNT_W  number of taken-branch flushes

Behaviour:
- Reset:
  - Asynchronous, active-high; no other reset path.
  - All slots get v=0 and all slot fields are zeroed.
  - Both counters are 0.
  - With all slots empty, every combinational output evaluates to 0.
- Slot contents: EX, MEM and WB slots each hold {v, rd, rw, mr, br}. The EX slot also holds {rs, rt, urs, urt}.
- Normal advance on every edge:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields, with v = in_ID_Valid.
- Load-use hazard (combinational):
  - hz = EX.v & EX.mr & EX.rd != 0 & in_ID_Valid & ((in_ID_Uses_Rs & in_ID_Rs == EX.rd) | (in_ID_Uses_Rt & in_ID_Rt == EX.rd)).
  - O_Stall = hz & ~take; O_IDEX_Bubble = O_Stall | take.
  - On a stall edge, EX is loaded with v=0 while MEM and WB advance normally.
  - The stall is exactly one cycle: the dependent instruction then enters EX while the load sits in WB and takes its data via O_Fwd=01.
- Branch:
  - take = EX.v & EX.br & in_EX_Zero.
  - O_PC_Src = take; O_Branch_Target = in_EX_addResult when take, else 0.
  - O_Flush = take. On that edge, EX is loaded with v=0, killing the ID instruction; IF/ID is cleared externally.
  - Penalty is 2 cycles.
  - take and hz in the same cycle: take wins, O_Stall=0, and the stall counter does not increment.
- Forwarding (combinational, for the EX slot; shown for A, identical for B with rt/urt):
  - 10 (MEM) if EX.urs & MEM.v & MEM.rw & MEM.rd != 0 & MEM.rd == EX.rs.
  - Otherwise 01 (WB) under the same conditions against WB.
  - Otherwise 00 (register file).
  - MEM has priority over WB; rd=0 is never forwarded; an invalid EX slot gives 00.
- Counters:
  - O_Stall_Count increments on every edge where O_Stall=1.
  - O_Flush_Count increments on every edge where take=1.
  - Both wrap modulo 2^CNT_W and are cleared only by rst.
- Reset mid-operation: all slots are invalidated immediately and outputs fall to 0 asynchronously. There is no pending stall or flush after reset is released.
- The block has no handshake with memory and always advances; a global freeze is out of scope.

Decomposition:
- Shared package contents:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Slot record typedef {v, rd, rw, mr, br}.
  - REG_ADDR_W default.
- One natural sub-module, ex_fwd_select, instantiated twice (A and B):
  - Inputs: src reg, use flag, MEM {v, rw, rd}, WB {v, rw, rd}.
  - Output: 2-bit select.

Test Plan:
- Load-use on Rs: load r2 enters EX, then ID reads Rs=r2 -> O_Stall=1 and O_IDEX_Bubble=1 for exactly 1 cycle. Next cycle O_Stall=0; the cycle after, O_FwdA=01. O_Stall_Count=1.
- Double hazard: EX add writes r3 and the instruction behind it also writes r3 -> an EX reader of r3 gets O_FwdB=10 (MEM wins over WB). A reader of r0 always gets 00.
- Branch taken: EX branch with in_EX_Zero=1 and in_EX_addResult=16'h0040 -> O_PC_Src=1, O_Branch_Target=16'h0040, O_Flush=1 for one cycle. The next EX slot is invalid (O_FwdA=O_FwdB=00). O_Flush_Count=1.
- Branch not taken (in_EX_Zero=0) -> O_PC_Src=0, O_Flush=0, O_Branch_Target=0; the pipeline advances normally.
- Simultaneous events: branch taken in EX while ID holds a load-use hazard against EX -> O_Flush=1, O_Stall=0. Stall count unchanged, flush count +1.
- Reset mid-stall: assert rst asynchronously while O_Stall=1 -> all outputs are 0 before the next clock edge and both counters are 0. After release, an ID instruction with no dependencies passes with no stall.

Source files
------------

// File: rtl/ex_hazard_controller_pkg.sv
// Shared types and constants for the EX-stage hazard controller:
// forwarding select encodings and the per-slot pipeline record.
package ex_hazard_controller_pkg;

   localparam int DEF_REG_ADDR_W = 3;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Destination/control info tracked for every shadow pipeline slot
   typedef struct packed {
      logic                      v;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic                      rw;
      logic                      mr;
      logic                      br;
   } slot_t;

endpackage

// File: rtl/ex_hazard_controller_fwd_select.sv
// Operand forwarding select for one EX source operand; MEM result beats WB,
// and register 0 is never forwarded.
module ex_fwd_select
   import ex_hazard_controller_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] src_i,
   input  logic                  use_i,
   input  logic                  mem_v_i,
   input  logic                  mem_rw_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic                  wb_v_i,
   input  logic                  wb_rw_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   output logic [1:0]            sel_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = use_i & mem_v_i & mem_rw_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
   assign wb_hit  = use_i & wb_v_i  & wb_rw_i  & (wb_rd_i  != '0) & (wb_rd_i  == src_i);

   always_comb begin
      sel_o = FWD_REG;
      if (mem_hit) begin
         sel_o = FWD_MEM;
      end else if (wb_hit) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/ex_hazard_controller.sv
// EX-stage pipeline controller: shadow EX/MEM/WB slots drive operand forwarding,
// one-cycle load-use stalls and taken-branch flushes, with event counters.
module ex_hazard_controller
   import ex_hazard_controller_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_ID_Valid,
   input  logic [REG_ADDR_W-1:0] in_ID_Rs,
   input  logic [REG_ADDR_W-1:0] in_ID_Rt,
   input  logic                  in_ID_Uses_Rs,
   input  logic                  in_ID_Uses_Rt,
   input  logic [REG_ADDR_W-1:0] in_ID_Rd,
   input  logic                  in_ID_RegWrite,
   input  logic                  in_ID_MemRead,
   input  logic                  in_ID_Branch,
   input  logic                  in_EX_Zero,
   input  logic [DATA_W-1:0]     in_EX_addResult,
   output logic                  O_Stall,
   output logic                  O_Flush,
   output logic                  O_IDEX_Bubble,
   output logic [1:0]            O_FwdA,
   output logic [1:0]            O_FwdB,
   output logic                  O_PC_Src,
   output logic [DATA_W-1:0]     O_Branch_Target,
   output logic [CNT_W-1:0]      O_Stall_Count,
   output logic [CNT_W-1:0]      O_Flush_Count
);

   slot_t                 ex_q, ex_d, mem_q, wb_q;
   logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
   logic                  ex_urs_q, ex_urs_d, ex_urt_q, ex_urt_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic                  hz, take, stall, kill;
   logic                  wb_unused;

   // WB only feeds forwarding; its load/branch flags are carried for visibility
   assign wb_unused = ^{wb_q.mr, wb_q.br};

   assign hz = ex_q.v & ex_q.mr & (ex_q.rd != '0) & in_ID_Valid &
               ((in_ID_Uses_Rs & (in_ID_Rs == ex_q.rd)) |
                (in_ID_Uses_Rt & (in_ID_Rt == ex_q.rd)));
   assign take  = ex_q.v & ex_q.br & in_EX_Zero;
   assign stall = hz & ~take;
   assign kill  = stall | take;

   assign O_Stall         = stall;
   assign O_Flush         = take;
   assign O_IDEX_Bubble   = kill;
   assign O_PC_Src        = take;
   assign O_Branch_Target = take ? in_EX_addResult : '0;
   assign O_Stall_Count   = stall_cnt_q;
   assign O_Flush_Count   = flush_cnt_q;

   // A stalled or wrong-path ID instruction enters EX as an empty slot
   always_comb begin
      ex_d     = '0;
      ex_rs_d  = '0;
      ex_rt_d  = '0;
      ex_urs_d = 1'b0;
      ex_urt_d = 1'b0;
      if (!kill) begin
         ex_d.v   = in_ID_Valid;
         ex_d.rd  = in_ID_Rd;
         ex_d.rw  = in_ID_RegWrite;
         ex_d.mr  = in_ID_MemRead;
         ex_d.br  = in_ID_Branch;
         ex_rs_d  = in_ID_Rs;
         ex_rt_d  = in_ID_Rt;
         ex_urs_d = in_ID_Uses_Rs;
         ex_urt_d = in_ID_Uses_Rt;
      end
   end

   assign stall_cnt_d = stall_cnt_q + CNT_W'(stall);
   assign flush_cnt_d = flush_cnt_q + CNT_W'(take);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_urs_q    <= 1'b0;
         ex_urt_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= ex_q;
         wb_q        <= mem_q;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_urs_q    <= ex_urs_d;
         ex_urt_q    <= ex_urt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   ex_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src_i    (ex_rs_q),
      .use_i    (ex_q.v & ex_urs_q),
      .mem_v_i  (mem_q.v),
      .mem_rw_i (mem_q.rw),
      .mem_rd_i (mem_q.rd),
      .wb_v_i   (wb_q.v),
      .wb_rw_i  (wb_q.rw),
      .wb_rd_i  (wb_q.rd),
      .sel_o    (O_FwdA)
   );

   ex_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src_i    (ex_rt_q),
      .use_i    (ex_q.v & ex_urt_q),
      .mem_v_i  (mem_q.v),
      .mem_rw_i (mem_q.rw),
      .mem_rd_i (mem_q.rd),
      .wb_v_i   (wb_q.v),
      .wb_rw_i  (wb_q.rw),
      .wb_rd_i  (wb_q.rd),
      .sel_o    (O_FwdB)
   );

endmodule
